seg7_capture: RTL

Receiving end of the board's 7-segment display path: samples a multiplexed, active-low segment/anode bus, waits for each digit's pattern to settle, maps the pattern back to its 4-bit code, and assembles a complete multi-digit value. It is the inverse of the nibble-to-segment encoder used across the lab designs and uses the same 16-entry pattern set. Used to loop back display output into self-checking benches and to read an external scanned display into the datapath.

---
 rtl/seg7_capture_if.sv | 23 ++
 rtl/seg7_capture.sv | 134 +++++++++++++
 2 files changed

// File: rtl/seg7_capture_if.sv
// Display-side bus of seg7_capture: the scanned segment/anode inputs and the
// reassembled frame outputs.
interface seg7_capture_if #(
  parameter int DIGITS = 4
);
  logic [6:0]          seg_in;
  logic [DIGITS-1:0]   an_in;
  logic [4*DIGITS-1:0] value;
  logic                value_valid;
  logic                digit_err;
  logic [DIGITS-1:0]   captured_mask;

  // master drives the display pins; slave is the capture block
  modport master (
    output seg_in, an_in,
    input  value, value_valid, digit_err, captured_mask
  );

  modport slave (
    input  seg_in, an_in,
    output value, value_valid, digit_err, captured_mask
  );
endinterface

// File: rtl/seg7_capture.sv
// Samples a multiplexed active-low 7-segment display, waits for each digit to
// settle, decodes it back to a nibble and assembles complete multi-digit frames.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_SETTLE | sample changed recently; waiting for STABLE_CYCLES repeats
// S_HOLD   | digit already committed for this dwell; wait for a change
module seg7_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst,
  seg7_capture_if.slave  bus
);

  localparam int         SW     = 7 + DIGITS;
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  typedef enum logic {S_SETTLE, S_HOLD} state_e;

  state_e              state_q, state_d;
  logic [SW-1:0]       sample_q, sample_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [4*DIGITS-1:0] staging_q, staging_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  logic                same;
  logic [DIGITS-1:0]   sel_oh;
  logic                sel_ok;
  logic [3:0]          code;
  logic                code_ok;
  logic [DIGITS-1:0]   mask_new;

  always_comb begin
    code    = 4'h0;
    code_ok = 1'b1;
    case (bus.seg_in)
      7'b1000000: code = 4'h0;
      7'b1111001: code = 4'h1;
      7'b0100100: code = 4'h2;
      7'b0110000: code = 4'h3;
      7'b0011001: code = 4'h4;
      7'b0010010: code = 4'h5;
      7'b0000010: code = 4'h6;
      7'b1111000: code = 4'h7;
      7'b0000000: code = 4'h8;
      7'b0011000: code = 4'h9;
      7'b0100111: code = 4'hA;
      7'b0110011: code = 4'hB;
      7'b0011101: code = 4'hC;
      7'b0010110: code = 4'hD;
      7'b0000111: code = 4'hE;
      7'b1111111: code = 4'hF;
      default:    code_ok = 1'b0;
    endcase
  end

  // Decisions are taken on the sample being registered this edge, so a commit
  // lands on the STABLE_CYCLES-th identical sample rather than one edge later.
  always_comb begin
    sample_d  = {bus.seg_in, bus.an_in};
    same      = (sample_d == sample_q);
    cnt_d     = same ? ((cnt_q >= STABLE) ? cnt_q : cnt_q + 8'd1) : 8'd1;
    sel_oh    = ~bus.an_in;
    sel_ok    = $onehot(sel_oh);
    mask_new  = mask_q | sel_oh;

    state_d   = state_q;
    staging_d = staging_q;
    value_d   = value_q;
    mask_d    = mask_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_SETTLE: begin
        if (cnt_d == STABLE && sel_ok) begin
          state_d = S_HOLD;
          if (code_ok) begin
            for (int i = 0; i < DIGITS; i++) begin
              if (sel_oh[i]) staging_d[4*i +: 4] = code;
            end
            if (&mask_new) begin
              value_d = staging_d;
              valid_d = 1'b1;
              mask_d  = '0;
            end else begin
              mask_d  = mask_new;
            end
          end else begin
            err_d  = 1'b1;
            mask_d = mask_q & ~sel_oh;
          end
        end
      end
      S_HOLD: begin
        if (!same) state_d = S_SETTLE;
      end
      default: state_d = S_SETTLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_SETTLE;
      sample_q  <= '0;
      cnt_q     <= '0;
      staging_q <= '0;
      value_q   <= '0;
      mask_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      cnt_q     <= cnt_d;
      staging_q <= staging_d;
      value_q   <= value_d;
      mask_q    <= mask_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign bus.value         = value_q;
  assign bus.value_valid   = valid_q;
  assign bus.digit_err     = err_q;
  assign bus.captured_mask = mask_q;

endmodule
